sierpinski_row_checker: RTL



---
 rtl/sierpinski_row_checker.sv | 111 +++++++++++
 1 files changed

// File: rtl/sierpinski_row_checker.sv
// Sierpinski (Rule-90) row checker.
// Checks that a frame of ROWS rows starts with SEED and that every later row
// equals the Rule-90 successor of the row before it. Stops at the first
// mismatch and reports its row index and XOR difference.
module sierpinski_row_checker #(
  parameter int unsigned ROWS = 20,
  parameter logic [15:0] SEED = 16'h0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] row_in,
  input  logic        row_valid,
  output logic        row_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  err_row,
  output logic [15:0] err_bits,
  output logic [4:0]  row_count
);

  typedef enum logic [1:0] {StIdle, StSeed, StCheck, StDone} state_e;

  localparam logic [4:0] RowsW = 5'(ROWS);

  state_e      state_q, state_d;
  logic [15:0] prev_q;
  logic [4:0]  row_count_q;
  logic        error_q;
  logic [4:0]  err_row_q;
  logic [15:0] err_bits_q;

  logic [15:0] expected;
  logic        accept;
  logic        mismatch;
  logic        last_row;
  logic        start_ok;

  // Expected row: SEED for row 0, Rule-90 successor of prev afterwards.
  // Bits shifted past either end of the word are dropped.
  always_comb begin
    expected = ({prev_q[14:0], 1'b0} ^ {1'b0, prev_q[15:1]});
    if (state_q == StSeed) begin
      expected = SEED;
    end
  end

  assign accept   = row_valid & row_ready;
  assign mismatch = (row_in != expected);
  assign last_row = ((row_count_q + 5'd1) == RowsW);
  // start only counts between frames.
  assign start_ok = start & ((state_q == StIdle) | (state_q == StDone));

  // State register plus frame datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      prev_q      <= 16'h0000;
      row_count_q <= 5'd0;
      error_q     <= 1'b0;
      err_row_q   <= 5'd0;
      err_bits_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        row_count_q <= 5'd0;
        error_q     <= 1'b0;
        err_row_q   <= 5'd0;
        err_bits_q  <= 16'h0000;
      end else if (accept) begin
        prev_q      <= row_in;
        row_count_q <= row_count_q + 5'd1;
        if (mismatch) begin
          error_q    <= 1'b1;
          err_row_q  <= row_count_q;
          err_bits_q <= row_in ^ expected;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) state_d = StSeed;
      end
      StSeed, StCheck: begin
        if (accept) begin
          if (mismatch || last_row) state_d = StDone;
          else                      state_d = StCheck;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state only, so row_ready never sees row_valid.
  always_comb begin
    row_ready = (state_q == StSeed) || (state_q == StCheck);
    busy      = (state_q == StSeed) || (state_q == StCheck);
    done      = (state_q == StDone);
    error     = error_q;
    err_row   = err_row_q;
    err_bits  = err_bits_q;
    row_count = row_count_q;
  end

endmodule
